// File: rtl/fpu_issue_queue.sv
// Operand-issue buffer in front of the floating-point core: queues requests, issues one at a time,
// and holds each result for a valid/ready consumer. Optional FPU_ISSUE_TAG_EN adds a 4-bit result tag.
module fpu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_op,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic                   core_start,
    output logic                   core_op,
    output logic [WIDTH-1:0]       core_a,
    output logic [WIDTH-1:0]       core_b,
    input  logic                   core_busy,
    input  logic                   core_ready,
    input  logic [WIDTH-1:0]       core_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_data,
`ifdef FPU_ISSUE_TAG_EN
    output logic [3:0]             res_tag,
`endif
    output logic [$clog2(DEPTH):0] count,
    output logic [1:0]             dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t           state;
    logic             op_mem [DEPTH];
    logic [WIDTH-1:0] a_mem  [DEPTH];
    logic [WIDTH-1:0] b_mem  [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             issue;

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
    // waits for ready, and the offered payload holds until the transfer completes.
    assign in_ready  = (count != FULL_COUNT);
    assign push      = in_valid && in_ready;
    assign pop       = (state == ST_START);
    assign issue     = (state == ST_IDLE) && (count != '0) && !core_busy && !res_valid;
    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (push) begin
            op_mem[wr_ptr] <= in_op;
            a_mem[wr_ptr]  <= in_a;
            b_mem[wr_ptr]  <= in_b;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // The head entry is latched onto the core operands on the issue edge, so the FIFO
    // pop can lag by one cycle (START) without exposing a bypass path.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            core_start <= 1'b0;
            core_op    <= 1'b0;
            core_a     <= '0;
            core_b     <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
        end else begin
            core_start <= 1'b0;
            if (res_valid && res_ready) res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state      <= ST_START;
                        core_start <= 1'b1;
                        core_op    <= op_mem[rd_ptr];
                        core_a     <= a_mem[rd_ptr];
                        core_b     <= b_mem[rd_ptr];
                    end
                end
                ST_START: state <= ST_WAIT;
                ST_WAIT: begin
                    if (core_ready) begin
                        res_data  <= core_data;
                        res_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FPU_ISSUE_TAG_EN
    logic [3:0] tag_cnt;
    logic [3:0] flight_tag;

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_cnt    <= 4'd0;
            flight_tag <= 4'd0;
            res_tag    <= 4'd0;
        end else begin
            if (issue) begin
                flight_tag <= tag_cnt;
                tag_cnt    <= tag_cnt + 4'd1;
            end
            if ((state == ST_WAIT) && core_ready) res_tag <= flight_tag;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Bench for fpu_issue_queue: directed scenarios plus random traffic against a queue-based
// reference model, with a behavioural core model driving the core-side handshake.
module tb_fpu_issue_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_op = 1'b0;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             core_start;
    logic             core_op;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic             core_busy = 1'b0;
    logic             core_ready = 1'b0;
    logic [WIDTH-1:0] core_data = '0;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [WIDTH-1:0] res_data;
`ifdef FPU_ISSUE_TAG_EN
    logic [3:0]       res_tag;
`endif
    logic [2:0]       count;
    logic [1:0]       dbg_state;

    fpu_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .core_start(core_start), .core_op(core_op), .core_a(core_a), .core_b(core_b),
        .core_busy(core_busy), .core_ready(core_ready), .core_data(core_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef FPU_ISSUE_TAG_EN
        .res_tag(res_tag),
`endif
        .count(count), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- core behaviour / reference function ----------------
    bit               fixed_en = 1'b0;
    logic [WIDTH-1:0] fixed_val = '0;
    bit               hold_busy = 1'b0;
    int               core_lat = 5;
    int               spur_req = 0;

    function automatic logic [WIDTH-1:0] exp_fn(input logic op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        if (fixed_en) return fixed_val;
        return op ? (a + b) : (a ^ b);
    endfunction

    initial begin : core_model
        bit               st_pend;
        logic             st_op;
        logic [WIDTH-1:0] st_a, st_b, core_res;
        bit               core_act;
        int               core_cnt;
        int               spur_done;
        core_act = 0; core_cnt = 0; spur_done = 0; core_res = '0;
        forever begin
            @(negedge clock);
            st_pend = core_start; st_op = core_op; st_a = core_a; st_b = core_b;
            @(posedge clock); #1;
            core_ready = 1'b0;
            if (st_pend) begin
                core_act = 1; core_cnt = core_lat; core_res = exp_fn(st_op, st_a, st_b);
            end else if (core_act) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_act = 0; core_ready = 1'b1; core_data = core_res;
                end
            end else if (spur_req != spur_done) begin
                spur_done++; core_ready = 1'b1; core_data = $urandom;
            end
            core_busy = core_act || hold_busy;
        end
    end

    // ---------------- reference model + scoreboard monitor ----------------
    typedef struct packed {
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    req_t             req_q[$];
    logic [WIDTH-1:0] exp_q[$];
    bit               m_valid = 0;
    bit               in_wait = 0;
    int               n_res = 0;

    initial begin : monitor
        bit   acc;
        req_t r;
        forever begin
            @(negedge clock);
            if (reset) begin
                req_q.delete(); exp_q.delete();
                m_valid = 0; in_wait = 0; n_res = 0;
            end else begin
                check("count", count, req_q.size());
                check("in_ready", in_ready, req_q.size() < DEPTH);
                check("res_valid", res_valid, m_valid);
                if (m_valid) begin
                    if (exp_q.size() > 0) check("res_data", res_data, exp_q[0]);
                    else check("res_unexpected", res_valid, 0);
`ifdef FPU_ISSUE_TAG_EN
                    check("res_tag", res_tag, n_res % 16);
`endif
                end
                acc = in_valid && (req_q.size() < DEPTH);
                if (core_start) begin
                    check("issue_while_busy", {in_wait, m_valid}, 0);
                    if (req_q.size() > 0) begin
                        r = req_q.pop_front();
                        check("core_op", core_op, r.op);
                        check("core_a", core_a, r.a);
                        check("core_b", core_b, r.b);
                    end else begin
                        check("issue_from_empty", core_start, 0);
                    end
                end
                if (acc) begin
                    r.op = in_op; r.a = in_a; r.b = in_b;
                    req_q.push_back(r);
                    exp_q.push_back(exp_fn(in_op, in_a, in_b));
                end
                if (m_valid && res_ready) begin
                    void'(exp_q.pop_front());
                    m_valid = 0;
                    n_res++;
                end
                if (in_wait && core_ready) begin
                    m_valid = 1; in_wait = 0;
                end
                if (core_start) in_wait = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic obs();
        @(negedge clock);
    endtask

    task automatic drive_req(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        bit done;
        done = 0;
        for (int i = 0; i < bound; i++) begin
            obs();
            if (exp_q.size() == 0 && !res_valid) begin
                done = 1;
                break;
            end
        end
        check("drain_done", done, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int  starts;
        bit  found;
        bit  vseen;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        obs();
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_core_start", core_start, 0);
        check("rst_core_op", core_op, 0);
        check("rst_core_a", core_a, 0);
        check("rst_core_b", core_b, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);

        // single op: start two cycles after the push edge, one-cycle pulse
        step();
        fixed_en = 1'b1; fixed_val = 32'hDEADBEEF; core_lat = 5;
        drive_req(1'b1, 32'h59FD3D97, 32'h51E5F4BE);
        obs();
        check("t1_no_bypass", core_start, 0);
        step(); obs();
        check("t1_start", core_start, 1);
        check("t1_op", core_op, 1);
        check("t1_a", core_a, 32'h59FD3D97);
        check("t1_b", core_b, 32'h51E5F4BE);
        step(); obs();
        check("t1_single_pulse", core_start, 0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            obs();
            if (core_ready) begin found = 1; break; end
        end
        check("t1_core_ready_seen", found, 1);
        obs();
        check("t1_res_valid", res_valid, 1);
        check("t1_res_data", res_data, 32'hDEADBEEF);
        step();
        fixed_en = 1'b0;

        // fill / overflow with the core held busy
        obs(); hold_busy = 1'b1;
        step(); step();
        for (int i = 0; i < 5; i++) drive_req(1'($urandom), $urandom, $urandom);
        obs();
        check("t2_count_full", count, 4);
        check("t2_in_ready_low", in_ready, 0);
        hold_busy = 1'b0;
        starts = 0;
        for (int i = 0; i < 80; i++) begin
            obs();
            if (core_start) starts++;
        end
        check("t2_start_pulses", starts, 4);
        check("t2_count_empty", count, 0);

        // back-pressure on the result register
        step();
        res_ready = 1'b0;
        drive_req(1'b0, $urandom, $urandom);
        drive_req(1'b1, $urandom, $urandom);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            obs();
            if (res_valid) begin found = 1; break; end
        end
        check("t3_res_seen", found, 1);
        starts = 0;
        repeat (10) begin
            obs();
            if (core_start) starts++;
        end
        check("t3_no_issue_held", starts, 0);
        step(); res_ready = 1'b1;
        obs();
        step(); obs();
        check("t3_start_gap1", core_start, 0);
        step(); obs();
        check("t3_start_after_consume", core_start, 1);
        drain(100);

        // push coinciding with the START-cycle pop
        hold_busy = 1'b1;
        step(); step();
        drive_req(1'b0, $urandom, $urandom);
        drive_req(1'b1, $urandom, $urandom);
        obs();
        check("t4_count_pre", count, 2);
        hold_busy = 1'b0;
        step(); step();
        in_valid = 1'b1; in_op = 1'b0; in_a = $urandom; in_b = $urandom;
        obs();
        check("t4_start", core_start, 1);
        check("t4_count_start", count, 2);
        step(); in_valid = 1'b0;
        obs();
        check("t4_count_after", count, 2);
        drain(150);

        // reset while waiting on the core with three entries queued
        hold_busy = 1'b1;
        step(); step();
        for (int i = 0; i < 4; i++) drive_req(1'($urandom), $urandom, $urandom);
        obs();
        check("t5_count4", count, 4);
        hold_busy = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            obs();
            if (core_start) begin found = 1; break; end
        end
        check("t5_start_seen", found, 1);
        step(); obs();
        check("t5_count_wait", count, 3);
        step(); reset = 1'b1;
        obs();
        step(); reset = 1'b0;
        obs();
        check("t5_rst_count", count, 0);
        check("t5_rst_res_valid", res_valid, 0);
        check("t5_rst_core_start", core_start, 0);
        check("t5_rst_in_ready", in_ready, 1);
        step(); spur_req++;
        starts = 0; vseen = 0;
        for (int i = 0; i < 20; i++) begin
            obs();
            if (core_start) starts++;
            if (res_valid) vseen = 1;
        end
        check("t5_spurious_no_issue", starts, 0);
        check("t5_spurious_no_result", vseen, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step();
            core_lat  = $urandom_range(1, 6);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_op     = 1'($urandom);
            in_a      = $urandom;
            in_b      = $urandom;
            res_ready = ($urandom_range(0, 3) != 0);
        end
        step();
        in_valid = 1'b0; res_ready = 1'b1;
        drain(300);

`ifdef FPU_ISSUE_TAG_EN
        // tag sequence from reset: 0..15 then wrap to 0
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive_req(1'($urandom), $urandom, $urandom);
            drain(40);
            step();
        end
        check("tag_results", n_res, 17);
`endif

        obs();
        check("final_empty", exp_q.size() + req_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_issue_queue.md
# fpu_issue_queue

Operand-issue stage placed directly upstream of the floating-point core `top`, with ports `start`, `op`, `data_a`, `data_b`, `busy`, `ready` and `data_o`. It buffers operation requests in a small FIFO. It issues them to the core one at a time, sending a single-cycle start and only while the core is idle. It captures each result into a holding register offered downstream with a valid/ready handshake. This removes the hazard of back-to-back start pulses reaching the core while it is busy.

## Interface
- `DEPTH`, default 4: command FIFO entries; power of two, ≥2.
- `WIDTH`, default 32: operand/result width.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `in_valid` in 1: request present.
- `in_ready` out 1: FIFO can accept; equals `!full`.
- `in_op` in 1: operation select, forwarded unchanged to the core.
- `in_a`, `in_b` in WIDTH: operands.
- `core_start` out 1: one-cycle start pulse to core.
- `core_op` out 1; `core_a`, `core_b` out WIDTH: registered operands, stable from the start cycle until the core's `ready`.
- `core_busy` in 1; `core_ready` in 1: core status; `ready` is a one-cycle pulse.
- `core_data` in WIDTH: core result, valid while `core_ready`=1.
- `res_valid` out 1; `res_ready` in 1; `res_data` out WIDTH: result handshake.
- `count` out clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FIFO: a push occurs when `in_valid && in_ready`; a pop occurs only on issue.
  - Push and pop in the same cycle leave `count` unchanged.
  - No bypass: a request pushed into an empty FIFO is issued no earlier than the next cycle.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: go to START when `count>0 && !core_busy && !res_valid`.
  - START: `core_start`=1 for exactly one cycle. The head entry is already latched on `core_op/a/b`, and the FIFO is popped this cycle. Go to WAIT.
  - WAIT: on `core_ready`=1, latch `core_data` into `res_data`, set `res_valid`, and return to IDLE.
- Result register:
  - `res_valid` clears when `res_valid && res_ready`.
  - `res_data` holds its value while `res_valid`=1 and `res_ready`=0.
  - Issue is blocked while a result is unconsumed.
- `core_ready` outside WAIT is ignored (no capture, no state change).
- Ordering: results leave in request order; at most one operation is in flight.

## Timing
- Reset values:
  - `in_ready`=1, `core_start`=0, `core_op`=0, `core_a`=`core_b`=0.
  - `res_valid`=0, `res_data`=0, `count`=0, state IDLE.
- Request latency: a push accepted at edge N produces `core_start`=1 in cycle N+2, provided the core is idle and no result is held.
- Result latency: `core_ready` sampled at edge M gives `res_valid`=1 from cycle M+1.
- Issue spacing: the minimum gap between successive `core_start` pulses is core latency + 2 cycles. This includes the cycle in which `res_ready` consumes the prior result.
- Full FIFO: `in_ready`=0 and pushes are ignored. `in_ready` rises the cycle after a pop.
- Reset mid-operation (any state): next cycle matches the reset values. The FIFO is flushed and any in-flight result is discarded.

## Configuration
- `FPU_ISSUE_TAG_EN`
- Defined:
  - Adds a 4-bit wrapping sequence counter, reset to 0, incremented on each issue.
  - The tag is stored with the in-flight operation and presented on output `res_tag` [3:0] alongside `res_data`. The first result after reset carries tag 0; the 17th wraps to tag 0.
- Undefined: no `res_tag` port and no counter. Behaviour is otherwise identical.

## Test plan
- Single op: push op=1, a=0x59FD3D97, b=0x51E5F4BE into an empty queue.
  - Required: `core_start` high exactly 2 cycles later, for 1 cycle, with those operands.
  - Core model returns ready after 5 cycles with 0xDEADBEEF → `res_valid`=1 with `res_data`=0xDEADBEEF one cycle after `core_ready`.
- Fill/overflow: with DEPTH=4 and the core held busy, push 5 requests back-to-back.
  - Required: `count`=4, `in_ready`=0, and the 5th request is dropped.
  - Release busy → exactly 4 `core_start` pulses, in order.
- Back-pressure: hold `res_ready`=0 after the first result.
  - Required: no second `core_start` while `res_valid`=1; `res_data` is stable.
  - Assert `res_ready` → the next `core_start` is issued 2 cycles later.
- Simultaneous push and pop: `count`=2 and a push arrives in the START cycle → `count` stays 2.
- Reset mid-operation: assert `reset` in WAIT with 3 entries queued.
  - Required: next cycle `count`=0, `res_valid`=0, `core_start`=0.
  - A spurious `core_ready` afterwards is ignored.
- Tags (macro defined): issue 17 operations → `res_tag` sequence 0..15, 0.
